// File: rtl/rom_responder.sv
// rom_responder: serves 16-bit program-ROM words from a one-line 32-bit buffer,
// refilling the line from an SDRAM channel on a tag miss.
//
// state  | meaning
// IDLE   | wait for rom_req, capture rom_addr
// LOOKUP | compare buffer tag with captured pair address
// FETCH  | sdram_req high, wait for sdram_valid
// RESP   | rom_valid pulse, rom_data holds selected word
// HOLD   | one-cycle guard while the requester drops rom_req
module rom_responder #(
  parameter int ADDR_W = 23
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rom_req,
  input  logic [ADDR_W-1:0] rom_addr,
  output logic              rom_valid,
  output logic [15:0]       rom_data,
  input  logic              flush,
  output logic              sdram_req,
  output logic [ADDR_W-2:0] sdram_addr,
  input  logic              sdram_valid,
  input  logic [31:0]       sdram_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FETCH,
    S_RESP,
    S_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_line_data;
  logic [ADDR_W-2:0] r_line_tag;
  logic              r_line_valid;
  logic              r_fetch_flushed;
  logic              r_rom_valid;
  logic [15:0]       r_rom_data;
  logic              r_sdram_req;
  logic [ADDR_W-2:0] r_sdram_addr;

  logic              w_hit;
  logic              w_capture;
  logic              w_start_fetch;
  logic              w_load_line;
  logic              w_respond;
  logic [31:0]       w_resp_src;

  assign w_hit = r_line_valid && (r_line_tag == r_addr[ADDR_W-1:1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_capture     = 1'b0;
    w_start_fetch = 1'b0;
    w_load_line   = 1'b0;
    w_respond     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rom_req) begin
          w_capture = 1'b1;
          w_next    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_respond = 1'b1;
          w_next    = S_RESP;
        end else begin
          w_start_fetch = 1'b1;
          w_next        = S_FETCH;
        end
      end
      S_FETCH: begin
        if (sdram_valid) begin
          w_load_line = 1'b1;
          w_respond   = 1'b1;
          w_next      = S_RESP;
        end
      end
      S_RESP:  w_next = S_HOLD;
      S_HOLD:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // On a miss the word comes straight from the SDRAM beat, the line loads in parallel
  assign w_resp_src = (r_state == S_FETCH) ? sdram_q : r_line_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr          <= '0;
      r_line_data     <= '0;
      r_line_tag      <= '0;
      r_line_valid    <= 1'b0;
      r_fetch_flushed <= 1'b0;
      r_rom_valid     <= 1'b0;
      r_rom_data      <= '0;
      r_sdram_req     <= 1'b0;
      r_sdram_addr    <= '0;
    end else begin
      if (w_capture) r_addr <= rom_addr;

      r_rom_valid <= w_respond;
      if (w_respond) r_rom_data <= r_addr[0] ? w_resp_src[31:16] : w_resp_src[15:0];

      if (w_start_fetch) begin
        r_sdram_req  <= 1'b1;
        r_sdram_addr <= r_addr[ADDR_W-1:1];
      end else if (w_load_line) begin
        r_sdram_req  <= 1'b0;
      end

      // A flush seen anywhere in FETCH means the returning line is already stale
      if (w_start_fetch) r_fetch_flushed <= 1'b0;
      else if (flush)    r_fetch_flushed <= 1'b1;

      if (w_load_line) begin
        r_line_data <= sdram_q;
        r_line_tag  <= r_addr[ADDR_W-1:1];
      end

      if (flush)            r_line_valid <= 1'b0;
      else if (w_load_line) r_line_valid <= ~r_fetch_flushed;
    end
  end

  assign rom_valid  = r_rom_valid;
  assign rom_data   = r_rom_data;
  assign sdram_req  = r_sdram_req;
  assign sdram_addr = r_sdram_addr;

endmodule

// File: tb/tb_rom_responder.sv
// Scoreboard bench for rom_responder: a behavioural line-buffer model predicts
// hit/miss, word and latency; the bench also plays the SDRAM channel.
module tb_rom_responder;

  logic        clk;
  logic        reset_n;
  logic        rom_req;
  logic [22:0] rom_addr;
  logic        rom_valid;
  logic [15:0] rom_data;
  logic        flush;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_valid;
  logic [31:0] sdram_q;

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] exp_q[$];

  bit          m_valid;
  logic [21:0] m_tag;
  logic [31:0] m_data;

  rom_responder #(.ADDR_W(23)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .rom_valid  (rom_valid),
    .rom_data   (rom_data),
    .flush      (flush),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_valid(sdram_valid),
    .sdram_q    (sdram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Latency counts the cycle in which rom_req is first sampled in IDLE as cycle 1.
  task automatic do_req(input logic [22:0] addr, input int lat, input logic [31:0] q,
                        input bit flush_in_fetch);
    bit          miss;
    logic [31:0] src;
    logic [15:0] exp_d;
    logic [21:0] saddr;
    int          cyc, fcnt, pulses, vcyc;
    bit          saw_sreq;
    miss  = !(m_valid && m_tag == addr[22:1]);
    src   = miss ? q : m_data;
    exp_d = addr[0] ? src[31:16] : src[15:0];
    exp_q.push_back(exp_d);
    @(posedge clk); #1;
    rom_req  = 1'b1;
    rom_addr = addr;
    cyc = 0; fcnt = 0; pulses = 0; vcyc = 0; saw_sreq = 1'b0; saddr = '0;
    while (cyc < 200 && !(vcyc != 0 && cyc >= vcyc + 3)) begin
      @(posedge clk); #1;
      cyc++;
      sdram_valid = 1'b0;
      flush       = 1'b0;
      if (vcyc != 0 && cyc == vcyc + 1) rom_req = 1'b0;
      if (rom_valid) begin
        pulses++;
        if (vcyc == 0) begin
          vcyc = cyc;
          chk("rom_data", 32'(rom_data), 32'(exp_q.pop_front()));
        end
      end
      if (vcyc != 0 && cyc == vcyc + 2) chk("rom_data_hold", 32'(rom_data), 32'(exp_d));
      if (sdram_req) begin
        if (saw_sreq) chk("sdram_addr_stable", 32'(sdram_addr), 32'(saddr));
        else          saddr = sdram_addr;
        saw_sreq = 1'b1;
        fcnt++;
        if (flush_in_fetch && fcnt == 1) flush = 1'b1;
        if (fcnt == lat) begin
          sdram_valid = 1'b1;
          sdram_q     = q;
        end
      end
    end
    sdram_valid = 1'b0;
    flush       = 1'b0;
    rom_req     = 1'b0;
    if (vcyc == 0) begin
      chk("rom_valid_timeout", 32'(0), 32'(1));
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    chk("rom_valid_pulses", 32'(pulses), 32'(1));
    chk("latency", 32'(vcyc + 1), 32'(3 + (miss ? lat : 0)));
    chk("sdram_req_seen", 32'(saw_sreq), 32'(miss));
    if (miss) chk("sdram_addr", 32'(saddr), 32'(addr[22:1]));
    if (miss) begin
      m_data  = q;
      m_tag   = addr[22:1];
      m_valid = !flush_in_fetch;
    end
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush   = 1'b0;
    m_valid = 1'b0;
  endtask

  initial begin
    logic [22:0] pick[6];
    reset_n = 1'b0; rom_req = 1'b0; rom_addr = '0; flush = 1'b0;
    sdram_valid = 1'b0; sdram_q = '0;
    m_valid = 1'b0; m_tag = '0; m_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rom_valid", 32'(rom_valid), 32'(0));
    chk("rst_rom_data", 32'(rom_data), 32'(0));
    chk("rst_sdram_req", 32'(sdram_req), 32'(0));
    chk("rst_sdram_addr", 32'(sdram_addr), 32'(0));
    reset_n = 1'b1;

    do_req(23'h000010, 5, 32'hBEEF1234, 1'b0);   // cold miss
    do_req(23'h000011, 3, 32'h0, 1'b0);          // pair hit
    do_req(23'h400010, 2, 32'hCAFE0001, 1'b0);   // tag miss
    do_req(23'h400011, 2, 32'h0, 1'b0);
    do_req(23'h000010, 1, 32'hBEEF1234, 1'b0);
    pulse_flush();
    do_req(23'h000010, 3, 32'hBEEF1234, 1'b0);   // refetch after flush
    do_req(23'h000020, 4, 32'h5555AAAA, 1'b1);   // flush during fetch
    do_req(23'h000020, 4, 32'h5555AAAA, 1'b0);
    do_req(23'h000021, 4, 32'h0, 1'b0);
    do_req(23'h000040, 1, 32'h77778888, 1'b1);   // flush coincides with line load

    // sdram_valid outside FETCH must not disturb the line
    @(posedge clk); #1;
    sdram_valid = 1'b1; sdram_q = 32'hDEADDEAD;
    @(posedge clk); #1;
    sdram_valid = 1'b0;
    do_req(23'h000041, 2, 32'h13572468, 1'b0);
    do_req(23'h000040, 2, 32'h0, 1'b0);

    // rom_req dropped early on a hit: FSM must still return to IDLE
    @(posedge clk); #1;
    rom_req = 1'b1; rom_addr = 23'h000041;
    @(posedge clk); #1;
    rom_req = 1'b0;
    repeat (5) @(posedge clk);
    do_req(23'h000040, 2, 32'h0, 1'b0);

    pick[0] = 23'h000010; pick[1] = 23'h000011; pick[2] = 23'h400010;
    pick[3] = 23'h400011; pick[4] = 23'h000020; pick[5] = 23'h000021;
    for (int i = 0; i < 8; i++) begin
      do_req(pick[$urandom_range(5, 0)], int'($urandom_range(4, 1)), $urandom, 1'b0);
    end

    // Reset in the middle of a fetch, then a stray sdram_valid
    do_req(23'h000100, 2, 32'h11112222, 1'b0);
    @(posedge clk); #1;
    rom_req = 1'b1; rom_addr = 23'h000300;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_fetch", 32'(sdram_req), 32'(1));
    reset_n = 1'b0;
    rom_req = 1'b0;
    #1;
    chk("async_rst_sdram_req", 32'(sdram_req), 32'(0));
    chk("async_rst_sdram_addr", 32'(sdram_addr), 32'(0));
    chk("async_rst_rom_data", 32'(rom_data), 32'(0));
    chk("async_rst_rom_valid", 32'(rom_valid), 32'(0));
    m_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    sdram_valid = 1'b1; sdram_q = 32'h99998888;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      sdram_valid = 1'b0;
      chk("stray_rom_valid", 32'(rom_valid), 32'(0));
      chk("stray_outputs", {15'(rom_data), sdram_req, 16'(sdram_addr)}, 32'(0));
    end
    do_req(23'h000100, 3, 32'h33334444, 1'b0);   // first request after reset misses
    do_req(23'h000101, 3, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_responder.md
ROM_RESPONDER -- requirements
Module: rom_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, width of the 16-bit-word request address.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rom_req  input  1  level request from the program-ROM cache; held until rom_valid seen.
REQ-005 SHALL have port rom_addr  input  ADDR_W  16-bit word address; stable while rom_req high.
REQ-006 SHALL have port rom_valid  output  1  one-cycle pulse; rom_data valid in the same cycle.
REQ-007 SHALL have port rom_data  output  16  requested word.
REQ-008 SHALL have port flush  input  1  invalidates the line buffer (ROM reload).
REQ-009 SHALL have port sdram_req  output  1  level request to the SDRAM channel.
REQ-010 SHALL have port sdram_addr  output  ADDR_W-1  32-bit pair address, equal to rom_addr[ADDR_W-1:1].
REQ-011 SHALL have port sdram_valid  input  1  one-cycle pulse; sdram_q valid in the same cycle.
REQ-012 SHALL have port sdram_q  input  32  fetched pair; [15:0] is the even word, [31:16] the odd word.

Function
REQ-013 SHALL hold a one-line buffer: 32-bit data, tag (ADDR_W-1 bits), one valid bit.
REQ-014 SHALL implement states IDLE, LOOKUP, FETCH, RESP, HOLD.
REQ-015 IDLE: when rom_req=1, SHALL register rom_addr and go to LOOKUP.
REQ-016 LOOKUP: hit when the buffer is valid and the tag equals the registered addr[ADDR_W-1:1].
REQ-017 LOOKUP: on a hit, SHALL go to RESP.
REQ-018 LOOKUP: on a miss, SHALL set sdram_req=1, drive sdram_addr, and go to FETCH.
REQ-019 FETCH: on sdram_valid=1, SHALL clear sdram_req the next cycle.
REQ-020 FETCH: on sdram_valid=1, SHALL load data and tag, set the valid bit, and go to RESP.
REQ-021 RESP: SHALL drive rom_valid=1 for exactly one cycle.
REQ-022 RESP: rom_data SHALL be buffer[15:0] when the registered addr[0]=0, else buffer[31:16].
REQ-023 RESP: SHALL go to HOLD.
REQ-024 HOLD: SHALL ignore rom_req for one cycle (the requester drops it one cycle after rom_valid), then return to IDLE.
REQ-025 Hit latency SHALL be 3 cycles, counted from rom_req sampled high in IDLE to rom_valid.
REQ-026 Miss latency SHALL be 3 cycles plus the SDRAM latency.
REQ-027 rom_valid SHALL never be asserted twice for one request, and never outside RESP.
REQ-028 rom_data SHALL hold its last value outside RESP.
REQ-029 sdram_addr SHALL be stable while sdram_req=1.
REQ-030 sdram_req SHALL never be asserted outside FETCH.
REQ-031 flush=1 SHALL clear the valid bit in the same clock; it takes priority over a simultaneous line load.
REQ-032 flush during FETCH: returned data SHALL still be delivered via RESP, but SHALL NOT leave the buffer valid.
REQ-033 sdram_valid SHALL be ignored in any state other than FETCH.
REQ-034 rom_req falling before rom_valid is a protocol violation; the FSM SHALL still complete to IDLE without hanging.

Reset
REQ-035 reset_n=0 SHALL asynchronously force state=IDLE, rom_valid=0, rom_data=0, sdram_req=0, sdram_addr=0, buffer valid=0.
REQ-036 Reset during FETCH SHALL abandon the fetch; a late sdram_valid after release SHALL be ignored (REQ-033).
REQ-037 After release, the first request SHALL always miss.

Verification
REQ-038 Cold miss: rom_addr=0x000010, SDRAM returns 0xBEEF1234 after 5 cycles -> sdram_addr=0x000008, rom_data=0x1234, one rom_valid pulse.
REQ-039 Pair hit: next request rom_addr=0x000011 -> no sdram_req, rom_data=0xBEEF, rom_valid 3 cycles after rom_req.
REQ-040 Tag miss: rom_addr=0x400010 after REQ-039 -> sdram_req asserted with sdram_addr=0x200008, buffer replaced.
REQ-041 Flush: flush pulse between two requests to 0x000010 -> second request fetches from SDRAM again.
REQ-042 Flush during FETCH: data 0x5555AAAA still returned as 0xAAAA; a repeat request to the same address misses.
REQ-043 Reset mid-FETCH, then a stray sdram_valid -> all outputs 0, no rom_valid, next request misses.
